// File: rtl/ppc_types.sv
// Shared PowerPC issue-side types: trap decode word and the reservation-station
// operand record used by every station.
package ppc_types;

    // Widest tag any station may use; narrower rs_ids are zero-extended.
    localparam int RS_TAG_MAX_WIDTH = 8;

    typedef struct packed {
        logic [0:4] to;
    } trap_decode_t;

    typedef struct packed {
        logic                        rdy;
        logic [RS_TAG_MAX_WIDTH-1:0] tag;
        logic [31:0]                 value;
    } rs_operand_t;

endpackage

// File: rtl/trap_reservation_station_operand_slot.sv
// One operand of a station entry: captures at dispatch (with writeback bypass)
// and snoops the GPR writeback bus while waiting on its producer tag.
module rs_operand_slot
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   busy,
    input  logic [31:0]            in_value,
    input  logic                   in_rdy,
    input  logic [RS_ID_WIDTH-1:0] in_tag,
    input  logic                   wb_valid,
    input  logic [RS_ID_WIDTH-1:0] wb_rs_id,
    input  logic [31:0]            wb_value,
    output logic                   rdy,
    output logic [31:0]            value
);

    rs_operand_t op_q;
    logic        bypass_hit;
    logic        snoop_hit;

    assign bypass_hit = wb_valid && (wb_rs_id == in_tag);
    assign snoop_hit  = busy && !op_q.rdy && wb_valid
                        && (op_q.tag == RS_TAG_MAX_WIDTH'(wb_rs_id));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else if (load) begin
            op_q.tag <= RS_TAG_MAX_WIDTH'(in_tag);
            if (in_rdy) begin
                op_q.rdy   <= 1'b1;
                op_q.value <= in_value;
            end else if (bypass_hit) begin
                op_q.rdy   <= 1'b1;
                op_q.value <= wb_value;
            end else begin
                op_q.rdy   <= 1'b0;
                op_q.value <= in_value;
            end
        end else if (snoop_hit) begin
            op_q.rdy   <= 1'b1;
            op_q.value <= wb_value;
        end
    end

    assign rdy   = op_q.rdy;
    assign value = op_q.value;

endmodule

// File: rtl/trap_reservation_station.sv
// Reservation station for tw/twi: holds dispatched traps until both operands
// are known, then issues the lowest ready entry through a one-deep issue register.
module trap_reservation_station
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0,
    parameter int NUM_ENTRIES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [31:0]            op1_value,
    input  logic                   op1_rdy,
    input  logic [RS_ID_WIDTH-1:0] op1_tag,
    input  logic [31:0]            op2_value,
    input  logic                   op2_rdy,
    input  logic [RS_ID_WIDTH-1:0] op2_tag,
    input  trap_decode_t           control,
    input  logic                   wb_valid,
    input  logic [RS_ID_WIDTH-1:0] wb_rs_id,
    input  logic [31:0]            wb_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output trap_decode_t           issue_control
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] busy_q;
    trap_decode_t           control_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] op1_rdy_q, op2_rdy_q, alloc_we, cand;
    logic [31:0]            op1_val_q [NUM_ENTRIES];
    logic [31:0]            op2_val_q [NUM_ENTRIES];

    logic [IDX_W-1:0]       alloc_idx, sel_idx;
    logic                   dispatch_fire, issue_load;

    assign dispatch_ready = |(~busy_q);
    assign dispatch_fire  = dispatch_valid && dispatch_ready;
    assign cand           = busy_q & op1_rdy_q & op2_rdy_q;
    assign issue_load     = (!issue_valid || issue_ready) && (|cand);

    // NOTE: every variable gets a default before the loops so no latch is inferred.
    always_comb begin
        alloc_idx = '0;
        sel_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = IDX_W'(i);
            if (cand[i])    sel_idx   = IDX_W'(i);
        end
    end

    always_comb begin
        alloc_we = '0;
        if (dispatch_fire) alloc_we[alloc_idx] = 1'b1;
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        rs_operand_slot #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_op1 (
            .clk      (clk),
            .rst      (rst),
            .load     (alloc_we[g]),
            .busy     (busy_q[g]),
            .in_value (op1_value),
            .in_rdy   (op1_rdy),
            .in_tag   (op1_tag),
            .wb_valid (wb_valid),
            .wb_rs_id (wb_rs_id),
            .wb_value (wb_value),
            .rdy      (op1_rdy_q[g]),
            .value    (op1_val_q[g])
        );

        rs_operand_slot #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_op2 (
            .clk      (clk),
            .rst      (rst),
            .load     (alloc_we[g]),
            .busy     (busy_q[g]),
            .in_value (op2_value),
            .in_rdy   (op2_rdy),
            .in_tag   (op2_tag),
            .wb_valid (wb_valid),
            .wb_rs_id (wb_rs_id),
            .wb_value (wb_value),
            .rdy      (op2_rdy_q[g]),
            .value    (op2_val_q[g])
        );

        // The allocated entry is always free and the issued one always busy,
        // so set and clear never collide on the same entry.
        always_ff @(posedge clk) begin
            if (rst) begin
                busy_q[g]    <= 1'b0;
                control_q[g] <= '0;
            end else if (alloc_we[g]) begin
                busy_q[g]    <= 1'b1;
                control_q[g] <= control;
            end else if (issue_load && (sel_idx == IDX_W'(g))) begin
                busy_q[g]    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid   <= 1'b0;
            issue_rs_id   <= '0;
            issue_op1     <= '0;
            issue_op2     <= '0;
            issue_control <= '0;
        end else if (issue_load) begin
            issue_valid   <= 1'b1;
            issue_rs_id   <= RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx);
            issue_op1     <= op1_val_q[sel_idx];
            issue_op2     <= op2_val_q[sel_idx];
            issue_control <= control_q[sel_idx];
        end else if (issue_ready) begin
            issue_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trap_reservation_station.sv
// Directed scenario bench for trap_reservation_station (RS_OFFSET=0, 4 entries).
module tb_trap_reservation_station;
    import ppc_types::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               dispatch_valid, dispatch_ready;
    logic [31:0]        op1_value, op2_value;
    logic               op1_rdy, op2_rdy;
    logic [4:0]         op1_tag, op2_tag;
    trap_decode_t       control;
    logic               wb_valid;
    logic [4:0]         wb_rs_id;
    logic [31:0]        wb_value;
    logic               issue_valid, issue_ready;
    logic [4:0]         issue_rs_id;
    logic [31:0]        issue_op1, issue_op2;
    trap_decode_t       issue_control;

    int checks = 0;
    int errors = 0;

    trap_reservation_station #(.RS_ID_WIDTH(5), .RS_OFFSET(0), .NUM_ENTRIES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .op1_value      (op1_value),
        .op1_rdy        (op1_rdy),
        .op1_tag        (op1_tag),
        .op2_value      (op2_value),
        .op2_rdy        (op2_rdy),
        .op2_tag        (op2_tag),
        .control        (control),
        .wb_valid       (wb_valid),
        .wb_rs_id       (wb_rs_id),
        .wb_value       (wb_value),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs_id    (issue_rs_id),
        .issue_op1      (issue_op1),
        .issue_op2      (issue_op2),
        .issue_control  (issue_control)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [31:0] v1, input logic r1, input logic [4:0] t1,
                            input logic [31:0] v2, input logic r2, input logic [4:0] t2,
                            input logic [0:4] to);
        dispatch_valid = 1'b1;
        op1_value = v1; op1_rdy = r1; op1_tag = t1;
        op2_value = v2; op2_rdy = r2; op2_tag = t2;
        control.to = to;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        wb_valid       = 1'b0;
    endtask

    task automatic broadcast(input logic [4:0] id, input logic [31:0] v);
        wb_valid = 1'b1; wb_rs_id = id; wb_value = v;
    endtask

    task automatic expect_valid(input string name, input logic exp);
        checks++;
        if (issue_valid !== exp) begin
            errors++;
            $display("FAIL %s issue_valid got %b want %b", name, issue_valid, exp);
        end
    endtask

    task automatic expect_issue(input string name, input logic [4:0] id,
                                input logic [31:0] o1, input logic [31:0] o2);
        checks++;
        if (issue_valid !== 1'b1 || issue_rs_id !== id || issue_op1 !== o1 || issue_op2 !== o2) begin
            errors++;
            $display("FAIL %s got v=%b id=%0d op1=%h op2=%h want v=1 id=%0d op1=%h op2=%h",
                     name, issue_valid, issue_rs_id, issue_op1, issue_op2, id, o1, o2);
        end
    endtask

    task automatic expect_dready(input string name, input logic exp);
        checks++;
        if (dispatch_ready !== exp) begin
            errors++;
            $display("FAIL %s dispatch_ready got %b want %b", name, dispatch_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        issue_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (issue_valid !== 1'b0 || issue_rs_id !== 5'd0 || issue_op1 !== 32'd0 ||
            issue_op2 !== 32'd0 || issue_control !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b id=%0d op1=%h op2=%h ctl=%b want all zero",
                     issue_valid, issue_rs_id, issue_op1, issue_op2, issue_control);
        end
        expect_dready("reset_dready", 1'b1);
    endtask

    task automatic test_basic_issue();
        issue_ready = 1'b1;
        dispatch(32'd5, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 5'b00100);
        tick();
        idle();
        expect_valid("basic_not_yet", 1'b0);
        tick();
        expect_issue("basic_issue", 5'd0, 32'd5, 32'd5);
        checks++;
        if (issue_control.to !== 5'b00100) begin
            errors++;
            $display("FAIL basic_control got %b want 00100", issue_control.to);
        end
        tick();
        expect_valid("basic_drain", 1'b0);
    endtask

    task automatic test_snoop();
        issue_ready = 1'b1;
        dispatch(32'd0, 1'b0, 5'd7, 32'd3, 1'b1, 5'd0, 5'b11000);
        tick();
        idle();
        expect_valid("snoop_wait0", 1'b0);
        tick();
        expect_valid("snoop_wait1", 1'b0);
        tick();
        expect_valid("snoop_wait2", 1'b0);
        broadcast(5'd7, 32'hFFFF_FFFF);
        tick();
        idle();
        expect_valid("snoop_same_cycle", 1'b0);
        tick();
        expect_issue("snoop_issue", 5'd0, 32'hFFFF_FFFF, 32'd3);
        tick();
        expect_valid("snoop_drain", 1'b0);
    endtask

    task automatic test_bypass();
        issue_ready = 1'b1;
        dispatch(32'd1, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9, 5'b00010);
        broadcast(5'd9, 32'h10);
        tick();
        idle();
        expect_valid("bypass_not_yet", 1'b0);
        tick();
        expect_issue("bypass_issue", 5'd0, 32'd1, 32'h10);
        tick();
        expect_valid("bypass_drain", 1'b0);
    endtask

    task automatic test_full_backpressure();
        logic [4:0]  exp_id [4];
        logic [31:0] exp_op [4];
        exp_id = '{5'd0, 5'd1, 5'd2, 5'd3};
        exp_op = '{32'd102, 32'd101, 32'd103, 32'd104};
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dispatch(32'd100 + 32'(k), 1'b1, 5'd0, 32'd50, 1'b1, 5'd0, 5'b10000);
            tick();
            expect_dready($sformatf("full_dready_%0d", k), (k < 4) ? 1'b1 : 1'b0);
            if (k == 0) expect_valid("full_first", 1'b0);
            else        expect_issue($sformatf("full_hold_%0d", k), 5'd0, 32'd100, 32'd50);
        end
        idle();
        tick();
        expect_issue("full_hold_stable", 5'd0, 32'd100, 32'd50);
        expect_dready("full_still_full", 1'b0);
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_issue($sformatf("drain_%0d", k), exp_id[k], exp_op[k], 32'd50);
        end
        tick();
        expect_valid("drain_empty", 1'b0);
        expect_dready("drain_dready", 1'b1);
    endtask

    task automatic test_priority();
        issue_ready = 1'b1;
        dispatch(32'd0, 1'b0, 5'd10, 32'd1, 1'b1, 5'd0, 5'b01000);
        tick();
        dispatch(32'd2, 1'b1, 5'd0, 32'd0, 1'b0, 5'd11, 5'b01000);
        tick();
        dispatch(32'd0, 1'b0, 5'd10, 32'd3, 1'b1, 5'd0, 5'b01000);
        tick();
        idle();
        expect_valid("prio_waiting", 1'b0);
        broadcast(5'd10, 32'hAA);
        tick();
        idle();
        tick();
        expect_issue("prio_first_e0", 5'd0, 32'hAA, 32'd1);
        tick();
        expect_issue("prio_second_e2", 5'd2, 32'hAA, 32'd3);
        tick();
        expect_valid("prio_e1_still_waits", 1'b0);
        broadcast(5'd11, 32'hBB);
        tick();
        idle();
        tick();
        expect_issue("prio_e1", 5'd1, 32'd2, 32'hBB);
        tick();
        expect_valid("prio_drain", 1'b0);
    endtask

    task automatic test_reset_mid();
        issue_ready = 1'b0;
        dispatch(32'd7, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 5'b00001);
        tick();
        dispatch(32'd0, 1'b0, 5'd12, 32'd1, 1'b1, 5'd0, 5'b00001);
        tick();
        dispatch(32'd0, 1'b0, 5'd13, 32'd1, 1'b1, 5'd0, 5'b00001);
        tick();
        dispatch(32'd0, 1'b0, 5'd14, 32'd1, 1'b1, 5'd0, 5'b00001);
        tick();
        idle();
        expect_issue("rstmid_before", 5'd0, 32'd7, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_valid("rstmid_valid", 1'b0);
        expect_dready("rstmid_dready", 1'b1);
        issue_ready = 1'b1;
        for (int t = 12; t <= 14; t++) begin
            broadcast(5'(t), 32'h55);
            tick();
            expect_valid($sformatf("rstmid_snoop_%0d", t), 1'b0);
        end
        idle();
        tick();
        expect_valid("rstmid_after1", 1'b0);
        tick();
        expect_valid("rstmid_after2", 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        dispatch_valid = 1'b0;
        op1_value = '0; op1_rdy = 1'b0; op1_tag = '0;
        op2_value = '0; op2_rdy = 1'b0; op2_tag = '0;
        control = '0;
        wb_valid = 1'b0; wb_rs_id = '0; wb_value = '0;
        issue_ready = 1'b0;
        test_reset();
        test_basic_issue();
        test_snoop();
        test_bypass();
        test_full_backpressure();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
